branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
//
// PURPOSE
//  Controller for the 4-entry branch target buffer: owns the entry table (valid/tag/target) and per-entry
//  2-bit saturating direction FSMs, answers IF-stage lookups and applies MM-stage resolution updates.
//  Sits between fetch (next-PC mux) and the MM stage; also raises the mispredict flush and correct PC.
//
// PARAMETERS
//  ENTRIES   4   table depth; power of two; index = pc[IDXW+1:2], IDXW = $clog2(ENTRIES)
//  INIT_CNT  2'b01   counter value loaded at reset (weakly not-taken)
//
// PORTS
//  CLK            in   1   system clock, all state updates on rising edge
//  RST            in   1   synchronous, active-high reset
//  IFpc           in   32  fetch PC being looked up
//  PRtaken        out  1   predict taken: entry hit and counter[1]==1
//  PRbpc          out  32  predicted target (valid only when PRtaken)
//  MMvalid        in   1   MM stage holds a live conditional branch (beq/bne)
//  MMtaken        in   1   resolved direction
//  MMpc           in   32  PC of the resolved branch
//  MMbpc          in   32  resolved branch target
//  MMpredtaken    in   1   prediction carried down the pipe with that branch
//  MMstall        in   1   pipeline frozen; suppresses update and flush
//  mispredict     out  1   flush IF..EX this cycle
//  fixpc          out  32  PC to load on mispredict: MMbpc if MMtaken else MMpc+4
//
// BEHAVIOUR
//  - Reset (RST high at edge): all valid=0, tags/targets=0, counters=INIT_CNT. Outputs then: PRtaken=0,
//    mispredict=0, fixpc=MMpc+4 (combinational), PRbpc=0.
//  - Lookup: combinational, zero latency. hit = valid[i] & tag[i]==IFpc[31:IDXW+2]; PRtaken = hit & cnt[i][1].
//  - mispredict = MMvalid & ~MMstall & (MMtaken != MMpredtaken | (MMtaken & MMpredtaken & target stale)),
//    where target stale = MM-index entry target != MMbpc. Combinational, same cycle as MM.
//  - Update (edge, when MMvalid & ~MMstall), index j = MMpc[IDXW+1:2]:
//      hit  : counter steps FSM; if MMtaken write target=MMbpc.
//      miss & MMtaken : allocate/replace: valid=1, tag, target=MMbpc, counter=WT.
//      miss & ~MMtaken: no change.
//  - Counter FSM per entry: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11); taken moves right, not-taken moves left;
//    saturates at SNT on not-taken and at ST on taken (no wrap).
//  - Simultaneous lookup and update of the same index: lookup sees pre-edge (old) contents; no bypass.
//  - MMstall high: table frozen, mispredict forced 0; lookups continue.
//  - RST mid-operation: wins over any update in that cycle; table returns to reset state next cycle.
//  - fixpc arithmetic: 32-bit, MMpc+4 wraps modulo 2^32.
//
// STRUCTURE
//  - branch_buffer_types_pkg: tag_t, bbcnt_t enum {SNT,WNT,WT,ST}, bb_entry_t struct {valid,tag,target},
//    ENTRIES/IDXW constants. Shared with the buffer interface and hazard unit.
//  - One sub-module: bp_sat_counter (2-bit FSM, inputs en/taken, output state), instantiated ENTRIES times.
//  - Table as an array of bb_entry_t in this module; single write port, single combinational read port
//    plus one read at the MM index for target check.
//
// TESTING
//  1 Reset: RST=1 one cycle, then IFpc=0x00000040 -> PRtaken=0, mispredict=0; all counters read WNT.
//  2 Allocate: MMvalid=1, MMpc=0x44, MMtaken=1, MMbpc=0x80, MMpredtaken=0 -> mispredict=1, fixpc=0x80;
//    next cycle IFpc=0x44 -> PRtaken=1, PRbpc=0x80.
//  3 Saturation: 3 further taken updates at 0x44 -> counter ST; 1 not-taken -> WT, PRtaken still 1;
//    second not-taken -> WNT, PRtaken=0, fixpc=0x48 on the mispredicting not-taken.
//  4 Alias: entry at 0x44 valid; IFpc=0x54 (same index, other tag) -> PRtaken=0; taken update at 0x54
//    replaces entry, then IFpc=0x44 -> PRtaken=0.
//  5 Stall/same-cycle: MMstall=1 with taken update -> no table change, mispredict=0; update and lookup
//    same index same cycle -> lookup returns old value, new value visible next cycle.
//  6 RST asserted in the same cycle as an allocating update -> entry stays invalid.

Source files
------------

// File: rtl/branch_buffer_types_pkg.sv
// Shared types for the branch target buffer: entry layout, 2-bit direction
// counter encoding and table geometry. Used by the predictor controller, the
// buffer interface and the hazard unit.
package branch_buffer_types_pkg;

  localparam int ENTRIES = 4;
  localparam int IDXW    = $clog2(ENTRIES);
  // Tags are held at the widest size any legal table depth can need
  // (pc[31:2]); narrower tags are zero-extended.
  localparam int TAGW    = 30;

  typedef logic [TAGW-1:0] tag_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bbcnt_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] target;
  } bb_entry_t;

  // Tag = pc bits above the word offset and the index field.
  function automatic tag_t pc_tag(input logic [31:0] pc, input int idxw);
    return tag_t'(pc >> (idxw + 2));
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating branch direction counter (SNT <-> WNT <-> WT <-> ST).
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset (loads INIT)
//   en_i, taken_i   step toward ST on taken, toward SNT on not-taken
//   ld_i, ld_val_i  load a value directly (allocation); wins over en_i
//   state_o         current counter state (registered)
module bp_sat_counter
  import branch_buffer_types_pkg::*;
#(
  parameter bbcnt_t INIT = WNT
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  input  logic   taken_i,
  input  logic   ld_i,
  input  bbcnt_t ld_val_i,
  output bbcnt_t state_o
);

  bbcnt_t state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
    end else if (ld_i) begin
      state_q <= ld_val_i;
    end else if (en_i) begin
      case (state_q)
        SNT: state_q <= taken_i ? WNT : SNT;
        WNT: state_q <= taken_i ? WT  : SNT;
        WT:  state_q <= taken_i ? ST  : WNT;
        ST:  state_q <= taken_i ? ST  : WT;
        default: state_q <= INIT;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch target buffer controller: direct-mapped table of {valid,tag,target}
// plus one 2-bit direction counter per entry. Answers IF lookups
// combinationally and applies MM-stage resolutions on the clock edge.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   IFpc                   fetch PC to look up
//   PRtaken, PRbpc         prediction (hit & counter taken) and target
//   MMvalid..MMstall       resolved branch from MM stage
//   mispredict, fixpc      flush request and redirect PC
module branch_predict_ctrl #(
  parameter int         ENTRIES  = branch_buffer_types_pkg::ENTRIES,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IFpc,
  output logic        PRtaken,
  output logic [31:0] PRbpc,
  input  logic        MMvalid,
  input  logic        MMtaken,
  input  logic [31:0] MMpc,
  input  logic [31:0] MMbpc,
  input  logic        MMpredtaken,
  input  logic        MMstall,
  output logic        mispredict,
  output logic [31:0] fixpc
);
  import branch_buffer_types_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  bb_entry_t  tbl_q [ENTRIES];
  bbcnt_t     cnt   [ENTRIES];

  logic [IDX_W-1:0] if_idx, mm_idx;
  tag_t             if_tag, mm_tag;
  logic             if_hit, mm_hit, upd, stale;

  assign if_idx = IFpc[IDX_W+1:2];
  assign mm_idx = MMpc[IDX_W+1:2];
  assign if_tag = pc_tag(IFpc, IDX_W);
  assign mm_tag = pc_tag(MMpc, IDX_W);

  // Read port 1: fetch lookup (sees pre-edge contents, no bypass).
  assign if_hit  = tbl_q[if_idx].valid && (tbl_q[if_idx].tag == if_tag);
  assign PRtaken = if_hit && cnt[if_idx][1];
  assign PRbpc   = tbl_q[if_idx].target;

  // Read port 2: MM-index entry for hit detection and target check.
  assign mm_hit = tbl_q[mm_idx].valid && (tbl_q[mm_idx].tag == mm_tag);
  assign stale  = tbl_q[mm_idx].target != MMbpc;
  assign upd    = MMvalid && !MMstall;

  // A correctly predicted taken branch still flushes if the cached target
  // no longer matches the resolved one.
  assign mispredict = upd && ((MMtaken != MMpredtaken) ||
                              (MMtaken && MMpredtaken && stale));
  assign fixpc      = MMtaken ? MMbpc : (MMpc + 32'd4);

  // Single write port: any taken resolution writes the entry, which covers
  // both target refresh on hit and allocate/replace on miss.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < ENTRIES; k++) tbl_q[k] <= '0;
    end else if (upd && MMtaken) begin
      tbl_q[mm_idx] <= '{valid: 1'b1, tag: mm_tag, target: MMbpc};
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    logic sel, en, ld;
    assign sel = upd && (mm_idx == IDX_W'(i));
    assign en  = sel && mm_hit;
    // Fresh allocation starts weakly taken.
    assign ld  = sel && !mm_hit && MMtaken;

    bp_sat_counter #(.INIT(bbcnt_t'(INIT_CNT))) u_cnt (
      .clk_i    (CLK),
      .rst_i    (RST),
      .en_i     (en),
      .taken_i  (MMtaken),
      .ld_i     (ld),
      .ld_val_i (WT),
      .state_o  (cnt[i])
    );
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IFpc;
  logic        PRtaken;
  logic [31:0] PRbpc;
  logic        MMvalid, MMtaken, MMpredtaken, MMstall;
  logic [31:0] MMpc, MMbpc;
  logic        mispredict;
  logic [31:0] fixpc;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  branch_predict_ctrl dut (
    .CLK(CLK), .RST(RST), .IFpc(IFpc), .PRtaken(PRtaken), .PRbpc(PRbpc),
    .MMvalid(MMvalid), .MMtaken(MMtaken), .MMpc(MMpc), .MMbpc(MMbpc),
    .MMpredtaken(MMpredtaken), .MMstall(MMstall),
    .mispredict(mispredict), .fixpc(fixpc)
  );

  typedef struct {
    logic        rst;
    logic [31:0] ifpc;
    logic        mv, mt;
    logic [31:0] mpc, mbpc;
    logic        mp, ms;
    logic        e_pt;
    logic [31:0] e_bpc;
    logic        e_mis;
    logic [31:0] e_fix;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic rst, logic [31:0] ifpc, logic mv, logic mt,
                              logic [31:0] mpc, logic [31:0] mbpc, logic mp, logic ms,
                              logic e_pt, logic [31:0] e_bpc, logic e_mis, logic [31:0] e_fix);
    vec_t r;
    r.rst = rst; r.ifpc = ifpc; r.mv = mv; r.mt = mt; r.mpc = mpc; r.mbpc = mbpc;
    r.mp = mp; r.ms = ms; r.e_pt = e_pt; r.e_bpc = e_bpc; r.e_mis = e_mis; r.e_fix = e_fix;
    return r;
  endfunction

  // Idle cycle: no MM branch, MMpc=0 so fixpc=4.
  function automatic vec_t idle(logic [31:0] ifpc, logic e_pt, logic [31:0] e_bpc);
    return mk(0, ifpc, 0, 0, 0, 0, 0, 0, e_pt, e_bpc, 0, 32'h4);
  endfunction

  function automatic vec_t upd(logic [31:0] ifpc, logic mt, logic [31:0] mpc, logic [31:0] mbpc,
                               logic mp, logic ms, logic e_pt, logic [31:0] e_bpc,
                               logic e_mis, logic [31:0] e_fix);
    return mk(0, ifpc, 1, mt, mpc, mbpc, mp, ms, e_pt, e_bpc, e_mis, e_fix);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    RST = r.rst; IFpc = r.ifpc; MMvalid = r.mv; MMtaken = r.mt; MMpc = r.mpc;
    MMbpc = r.mbpc; MMpredtaken = r.mp; MMstall = r.ms;
  endtask

  task automatic chk_cnts(string tag);
    chk($sformatf("%s cnt0", tag), 32'(dut.g_cnt[0].u_cnt.state_q), 32'h1);
    chk($sformatf("%s cnt1", tag), 32'(dut.g_cnt[1].u_cnt.state_q), 32'h1);
    chk($sformatf("%s cnt2", tag), 32'(dut.g_cnt[2].u_cnt.state_q), 32'h1);
    chk($sformatf("%s cnt3", tag), 32'(dut.g_cnt[3].u_cnt.state_q), 32'h1);
  endtask

  initial begin
    // 1 reset / idle
    v.push_back(idle(32'h40, 0, 0));
    // 2 allocate at 0x44; same-cycle lookup of same index sees old (invalid)
    v.push_back(upd(32'h44, 1, 32'h44, 32'h80, 0, 0, 0, 0, 1, 32'h80));
    v.push_back(idle(32'h44, 1, 32'h80));
    // 3 three taken -> ST, then two not-taken -> WT -> WNT
    v.push_back(upd(32'h44, 1, 32'h44, 32'h80, 1, 0, 1, 32'h80, 0, 32'h80));
    v.push_back(upd(32'h44, 1, 32'h44, 32'h80, 1, 0, 1, 32'h80, 0, 32'h80));
    v.push_back(upd(32'h44, 1, 32'h44, 32'h80, 1, 0, 1, 32'h80, 0, 32'h80));
    v.push_back(upd(32'h44, 0, 32'h44, 32'h80, 1, 0, 1, 32'h80, 1, 32'h48));
    v.push_back(idle(32'h44, 1, 32'h80));
    v.push_back(upd(32'h44, 0, 32'h44, 32'h80, 1, 0, 1, 32'h80, 1, 32'h48));
    v.push_back(idle(32'h44, 0, 0));
    // stale target on predicted-taken taken branch; WNT -> WT, target 0x90
    v.push_back(upd(32'h44, 1, 32'h44, 32'h90, 1, 0, 0, 0, 1, 32'h90));
    v.push_back(idle(32'h44, 1, 32'h90));
    // 4 alias 0x54 on index 1
    v.push_back(idle(32'h54, 0, 0));
    v.push_back(upd(32'h54, 1, 32'h54, 32'hA0, 0, 0, 0, 0, 1, 32'hA0));
    v.push_back(idle(32'h44, 0, 0));
    v.push_back(idle(32'h54, 1, 32'hA0));
    // 5 stall: no allocate, no counter step, no flush; lookups continue
    v.push_back(upd(32'h54, 1, 32'h40, 32'hB0, 0, 1, 1, 32'hA0, 0, 32'hB0));
    v.push_back(idle(32'h40, 0, 0));
    v.push_back(upd(32'h54, 0, 32'h54, 32'hA0, 1, 1, 1, 32'hA0, 0, 32'h58));
    v.push_back(idle(32'h54, 1, 32'hA0));
    // not-taken miss leaves table alone
    v.push_back(upd(32'h40, 0, 32'h60, 32'h0, 0, 0, 0, 0, 0, 32'h64));
    v.push_back(idle(32'h60, 0, 0));
    // SNT saturation: WT -> WNT -> SNT -> SNT, then taken twice -> WT
    v.push_back(upd(32'h40, 0, 32'h54, 32'hA0, 1, 0, 0, 0, 1, 32'h58));
    v.push_back(upd(32'h40, 0, 32'h54, 32'hA0, 1, 0, 0, 0, 1, 32'h58));
    v.push_back(upd(32'h40, 0, 32'h54, 32'hA0, 1, 0, 0, 0, 1, 32'h58));
    v.push_back(idle(32'h54, 0, 0));
    v.push_back(upd(32'h40, 1, 32'h54, 32'hA0, 0, 0, 0, 0, 1, 32'hA0));
    v.push_back(idle(32'h54, 0, 0));
    v.push_back(upd(32'h40, 1, 32'h54, 32'hA0, 0, 0, 0, 0, 1, 32'hA0));
    v.push_back(idle(32'h54, 1, 32'hA0));
    // fixpc wrap
    v.push_back(mk(0, 32'h0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0));
    v.push_back(upd(32'h0, 0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 0, 1, 32'h0));

    // reset prelude
    drive(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    drive(idle(32'h44, 0, 0));
    #1;
    chk("reset PRtaken", 32'(PRtaken), 32'h0);
    chk("reset PRbpc", PRbpc, 32'h0);
    chk("reset mispredict", 32'(mispredict), 32'h0);
    chk("reset fixpc", fixpc, 32'h4);
    chk_cnts("reset");

    foreach (v[i]) begin
      @(negedge CLK);
      drive(v[i]);
      #1;
      chk($sformatf("row%0d PRtaken", i), 32'(PRtaken), 32'(v[i].e_pt));
      if (v[i].e_pt) chk($sformatf("row%0d PRbpc", i), PRbpc, v[i].e_bpc);
      chk($sformatf("row%0d mispredict", i), 32'(mispredict), 32'(v[i].e_mis));
      chk($sformatf("row%0d fixpc", i), fixpc, v[i].e_fix);
    end

    // 6 reset concurrent with an allocating update at 0x48 (index 2)
    @(negedge CLK);
    drive(mk(1, 32'h48, 1, 1, 32'h48, 32'hC0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    drive(idle(32'h48, 0, 0));
    #1;
    chk("rst+alloc PRtaken 0x48", 32'(PRtaken), 32'h0);
    chk_cnts("rst+alloc");
    @(negedge CLK);
    drive(idle(32'h54, 0, 0));
    #1;
    chk("rst clears 0x54", 32'(PRtaken), 32'h0);
    // table usable again after reset
    @(negedge CLK);
    drive(upd(32'h48, 1, 32'h48, 32'hC0, 0, 0, 0, 0, 1, 32'hC0));
    #1;
    chk("post-rst alloc mispredict", 32'(mispredict), 32'h1);
    @(negedge CLK);
    drive(idle(32'h48, 0, 0));
    #1;
    chk("post-rst alloc PRtaken", 32'(PRtaken), 32'h1);
    chk("post-rst alloc PRbpc", PRbpc, 32'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
